ft601_rx_if: RTL and testbench

Host-to-FPGA read engine for the FT601 in 245 synchronous FIFO mode. It runs entirely in the FT601 clock domain. When the device reports data (`ft601_rxf_n` low), the block requests the shared data bus from the write-side arbiter and runs the OE/RD read sequence. It captures words and byte enables into an internal first-word-fall-through FIFO, then releases the bus at burst end, on device empty, or when local space is exhausted.

---
 rtl/ft601_rx_if.sv | 250 +++++++++++++++++++++++++
 tb/tb_ft601_rx_if.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft601_rx_if.sv
// ---------------------------------------------------------------------------
// ft601_rx_if
//
// Host-to-FPGA read engine for an FT601 in 245 synchronous FIFO mode. It runs
// entirely in the FT601 clock domain. When the device reports data
// (ft601_rxf_n low) and there is room for at least two more words, the block
// requests the shared bus from the write-side arbiter and runs the OE/RD read
// sequence. Captured words and byte enables go into a first-word-fall-through
// FIFO. The bus is released at burst end, when the device runs empty, or when
// the FIFO fills.
//
// Optional build macro:
//   FT601_RX_STATS_EN : adds the rx_words / rx_bursts / rx_short outputs.
//
// Ports:
//   clk          FT601 clock
//   reset_n      asynchronous active-low reset
//   ft601_data   32-bit data bus from the device (tristate handled above)
//   ft601_be     4-bit byte enables from the device
//   ft601_rxf_n  device has data (active low)
//   ft601_oe_n   device output enable (active low, registered)
//   ft601_rd_n   device read strobe (active low, registered)
//   bus_req      request ownership of the FT601 bus
//   bus_gnt      write side has released data/be
//   rd_data      FIFO head word (FWFT), zero when empty
//   rd_be        FIFO head byte enables, zero when empty
//   rd_valid     FIFO non-empty
//   rd_en        pop the head word (ignored when rd_valid is low)
//   rd_count     number of words held
//   rx_words     (stats) total captured words, wrapping
//   rx_bursts    (stats) number of READ entries, wrapping
//   rx_short     (stats) sticky: a burst ended on rxf_n with no capture
// ---------------------------------------------------------------------------
module ft601_rx_if #(
   parameter int  DEPTH     = 16,
   parameter int  MAX_BURST = 256,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [31:0]   ft601_data,
   input  logic [3:0]    ft601_be,
   input  logic          ft601_rxf_n,
   output logic          ft601_oe_n,
   output logic          ft601_rd_n,
   output logic          bus_req,
   input  logic          bus_gnt,
   output logic [31:0]   rd_data,
   output logic [3:0]    rd_be,
   output logic          rd_valid,
   input  logic          rd_en,
   output logic [AW:0]   rd_count
`ifdef FT601_RX_STATS_EN
   ,
   output logic [31:0]   rx_words,
   output logic [15:0]   rx_bursts,
   output logic          rx_short
`endif
);

   localparam int CW = AW + 1;
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_REQ_MAX = CW'(DEPTH - 2);
   localparam logic [AW-1:0] PTR_ONE     = AW'(1);
   localparam logic [BW-1:0] BURST_ONE   = BW'(1);
   localparam logic [BW-1:0] BURST_MAX   = BW'(MAX_BURST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_OE,
      S_READ,
      S_END,
      S_TURN
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            oe_n_nxt;
   logic            rd_n_nxt;
   logic            req_nxt;

   logic [35:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic [BW-1:0]   burst_cnt;
   logic [BW-1:0]   burst_nxt;
   logic [35:0]     head;
   logic            push;
   logic            pop;

   // A word is taken on any edge where the registered strobes show an active
   // read and the device still reports data. The word on the edge where
   // rxf_n rises is therefore never captured.
   assign push = ~ft601_oe_n & ~ft601_rd_n & ~ft601_rxf_n;
   assign pop  = rd_en & rd_valid;

   // Occupancy after this edge, with simultaneous push and pop cancelling.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   // Captures in the current burst; OE opens a fresh burst.
   always_comb begin
      burst_nxt = burst_cnt;
      if (state == S_OE) begin
         burst_nxt = '0;
      end else if (push) begin
         burst_nxt = burst_cnt + BURST_ONE;
      end
   end

   // Next state plus next values of the registered bus outputs. The strobes
   // are decoded from the next state so that they line up with the state
   // register and leave the chip straight from flops.
   always_comb begin
      state_nxt = state;
      oe_n_nxt  = 1'b1;
      rd_n_nxt  = 1'b1;
      req_nxt   = 1'b1;

      case (state)
         S_IDLE: begin
            // Two free slots needed: the read pipeline can land one word
            // after the decision to stop.
            if (!ft601_rxf_n && (count <= CNT_REQ_MAX)) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (bus_gnt) begin
               state_nxt = S_OE;
            end
         end
         S_OE: begin
            state_nxt = S_READ;
         end
         S_READ: begin
            if (ft601_rxf_n || (burst_nxt == BURST_MAX) || (count_nxt == CNT_FULL)) begin
               state_nxt = S_END;
            end
         end
         S_END: begin
            state_nxt = S_TURN;
         end
         S_TURN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      case (state_nxt)
         S_IDLE: begin
            req_nxt = 1'b0;
         end
         S_OE, S_END: begin
            oe_n_nxt = 1'b0;
         end
         S_READ: begin
            oe_n_nxt = 1'b0;
            rd_n_nxt = 1'b0;
         end
         default: begin
            oe_n_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         ft601_oe_n <= 1'b1;
         ft601_rd_n <= 1'b1;
         bus_req    <= 1'b0;
      end else begin
         state      <= state_nxt;
         ft601_oe_n <= oe_n_nxt;
         ft601_rd_n <= rd_n_nxt;
         bus_req    <= req_nxt;
      end
   end

   // FIFO bookkeeping. Clearing the pointers and count on reset is enough to
   // discard every stored word, including any from an interrupted burst.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         burst_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count     <= count_nxt;
         burst_cnt <= burst_nxt;
      end
   end

   // Storage holds no reset; stale contents are never visible because the
   // outputs are gated by rd_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {ft601_be, ft601_data};
      end
   end

   assign head     = mem[rd_ptr];
   assign rd_valid = (count != '0);
   assign rd_count = count;
   assign rd_data  = rd_valid ? head[31:0]  : 32'h0;
   assign rd_be    = rd_valid ? head[35:32] : 4'h0;

`ifdef FT601_RX_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_words  <= '0;
         rx_bursts <= '0;
         rx_short  <= 1'b0;
      end else begin
         if (push) begin
            rx_words <= rx_words + 32'd1;
         end
         // OE always leads into READ, so it marks each READ entry.
         if (state == S_OE) begin
            rx_bursts <= rx_bursts + 16'd1;
         end
         if ((state == S_READ) && ft601_rxf_n && (burst_cnt == '0)) begin
            rx_short <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ft601_rx_if.sv
// ---------------------------------------------------------------------------
// tb_ft601_rx_if
//
// Bench for ft601_rx_if. A device model supplies numbered words while
// rxf_n is low, a registered arbiter answers bus_req (optionally after a
// programmable delay), and a queue model of the receive FIFO is compared with
// the DUT outputs on every falling edge. Popped words are also checked against
// the device's numbering so that loss, duplication or reordering shows up.
// ---------------------------------------------------------------------------
module tb_ft601_rx_if;

   localparam int DEPTH     = 16;
   localparam int MAX_BURST = 256;
   localparam int AW        = $clog2(DEPTH);

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic [31:0]   ft601_data;
   logic [3:0]    ft601_be;
   logic          ft601_rxf_n;
   logic          ft601_oe_n;
   logic          ft601_rd_n;
   logic          bus_req;
   logic          bus_gnt = 1'b0;
   logic [31:0]   rd_data;
   logic [3:0]    rd_be;
   logic          rd_valid;
   logic          rd_en   = 1'b0;
   logic [AW:0]   rd_count;
`ifdef FT601_RX_STATS_EN
   logic [31:0]   rx_words;
   logic [15:0]   rx_bursts;
   logic          rx_short;
`endif

   int            checks = 0;
   int            failures = 0;
   int            dev_total = 0;
   int            dev_ptr = 0;
   int            exp_next = 0;
   int            tot_caps = 0;
   int            burst_caps = 0;
   int            bursts[$];
   logic [35:0]   mq[$];
   int            cyc = 0;
   int            gnt_delay = 1;
   int            req_hi = 0;
   int            req_rise_cyc = 0;
   int            gnt_rise_cyc = 0;
   int            last_rdn_rise = 0;
   int            oe_wait = -1;

   always #5 clk = ~clk;

   ft601_rx_if #(
      .DEPTH     (DEPTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ft601_data  (ft601_data),
      .ft601_be    (ft601_be),
      .ft601_rxf_n (ft601_rxf_n),
      .ft601_oe_n  (ft601_oe_n),
      .ft601_rd_n  (ft601_rd_n),
      .bus_req     (bus_req),
      .bus_gnt     (bus_gnt),
      .rd_data     (rd_data),
      .rd_be       (rd_be),
      .rd_valid    (rd_valid),
      .rd_en       (rd_en),
      .rd_count    (rd_count)
`ifdef FT601_RX_STATS_EN
      ,
      .rx_words    (rx_words),
      .rx_bursts   (rx_bursts),
      .rx_short    (rx_short)
`endif
   );

   function automatic logic [31:0] word_data(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0001_0001;
   endfunction

   function automatic logic [3:0] word_be(input int i);
      return 4'(i) ^ 4'h9;
   endfunction

   // Device: presents word dev_ptr, reports data while words remain.
   assign ft601_rxf_n = (dev_ptr < dev_total) ? 1'b0 : 1'b1;
   assign ft601_data  = word_data(dev_ptr);
   assign ft601_be    = word_be(dev_ptr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Edge process: everything before #1 sees pre-edge values.
   always @(posedge clk) begin
      logic        cap;
      logic        pop;
      logic        pre_oe;
      logic        pre_rd;
      logic        pre_req;
      logic        pre_gnt;
      logic        gnt_nxt;
      logic [35:0] word;
      cap     = reset_n && !ft601_oe_n && !ft601_rd_n && !ft601_rxf_n;
      pop     = reset_n && rd_en && (mq.size() != 0);
      word    = {ft601_be, ft601_data};
      pre_oe  = ft601_oe_n;
      pre_rd  = ft601_rd_n;
      pre_req = bus_req;
      pre_gnt = bus_gnt;
      cyc++;
      if (pop) begin
         chk("pop_data", rd_data, word_data(exp_next));
         chk("pop_be", rd_be, word_be(exp_next));
         exp_next++;
         void'(mq.pop_front());
      end
      if (!reset_n) begin
         mq.delete();
      end else if (cap) begin
         mq.push_back(word);
      end
      req_hi  = pre_req ? req_hi + 1 : 0;
      gnt_nxt = pre_req && (req_hi >= gnt_delay);
      #1;
      if (cap) begin
         dev_ptr++;
         tot_caps++;
         burst_caps++;
      end
      bus_gnt = gnt_nxt;
      if (pre_oe && !ft601_oe_n) begin
         burst_caps = 0;
         chk("oe_after_gnt", cyc - gnt_rise_cyc, 1);
         oe_wait = cyc - req_rise_cyc;
      end
      if (!pre_rd && ft601_rd_n) begin
         bursts.push_back(burst_caps);
         last_rdn_rise = cyc;
      end
      if (pre_req && !bus_req && reset_n) begin
         chk("req_fall_after_rd", cyc - last_rdn_rise, 2);
      end
      if (!pre_req && bus_req) req_rise_cyc = cyc;
      if (!pre_gnt && bus_gnt) gnt_rise_cyc = cyc;
   end

   // Compare process: FIFO model against DUT, plus bus-protocol invariants.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("rd_valid", rd_valid, mq.size() != 0);
         chk("rd_count", rd_count, mq.size());
         if (mq.size() != 0) begin
            chk("rd_data", rd_data, mq[0][31:0]);
            chk("rd_be", rd_be, mq[0][35:32]);
         end else begin
            chk("rd_head_empty", {rd_be, rd_data}, 36'h0);
         end
         if (!bus_gnt) chk("strobes_without_gnt", {ft601_oe_n, ft601_rd_n}, 2'b11);
         if (!ft601_oe_n) chk("oe_without_req", bus_req, 1'b1);
      end
   end

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (n < budget && !(dev_ptr == dev_total && exp_next == dev_total && !bus_req)) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, n >= budget, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      int p0;
      int n;
      int n_req;
      int exp_b[3];
      exp_b = '{256, 256, 88};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_oe_n", ft601_oe_n, 1'b1);
      chk("rst_rd_n", ft601_rd_n, 1'b1);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_count", rd_count, 0);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_rd_be", rd_be, 4'h0);
      #2 reset_n = 1'b1;

      // Single burst of 10 words, consumer always ready
      @(negedge clk);
      rd_en = 1'b1;
      bursts.delete();
      c0 = tot_caps;
      dev_total += 10;
      wait_done("single_burst", 500);
      chk("s1_caps", tot_caps - c0, 10);
      chk("s1_nbursts", bursts.size(), 1);
      chk("s1_burst_len", (bursts.size() > 0) ? bursts[0] : -1, 10);
      chk("s1_delivered", exp_next, 10);
      chk("s1_req_to_oe", oe_wait, 2);

      // Burst limit: 600 words split 256/256/88
      @(negedge clk);
      bursts.delete();
      c0 = tot_caps;
      dev_total += 600;
      wait_done("burst_limit", 3000);
      chk("s2_caps", tot_caps - c0, 600);
      chk("s2_nbursts", bursts.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("s2_burst_len", (i < bursts.size()) ? bursts[i] : -1, exp_b[i]);
      end
      chk("s2_delivered", exp_next, 610);
`ifdef FT601_RX_STATS_EN
      chk("stats_words", rx_words, 610);
      chk("stats_bursts", rx_bursts, 4);
      chk("stats_short", rx_short, 1'b0);
`endif

      // Backpressure: no pops, FIFO fills to 16, stalls, then re-requests
      @(negedge clk);
      rd_en = 1'b0;
      c0 = tot_caps;
      p0 = dev_ptr;
      dev_total += 40;
      n = 0;
      while (n < 300 && !(mq.size() == 16 && !bus_req)) begin
         @(negedge clk);
         n++;
      end
      chk("bp_fill_timeout", n >= 300, 1'b0);
      n_req = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus_req) n_req++;
      end
      chk("bp_no_req_when_full", n_req, 0);
      chk("bp_count_full", rd_count, 16);
      chk("bp_taken", dev_ptr - p0, 16);
      rd_en = 1'b1;
      repeat (2) @(negedge clk);
      rd_en = 1'b0;
      n = 0;
      while (n < 20 && !bus_req) begin
         @(negedge clk);
         n++;
      end
      chk("bp_rereq_timeout", n >= 20, 1'b0);
      rd_en = 1'b1;
      wait_done("backpressure", 1500);
      chk("bp_caps", tot_caps - c0, 40);
      chk("bp_delivered", exp_next, 650);

      // Delayed grant: grant withheld for 20 cycles of request
      @(negedge clk);
      gnt_delay = 21;
      dev_total += 5;
      wait_done("delayed_grant", 500);
      chk("dg_req_to_oe", oe_wait, 22);
      chk("dg_delivered", exp_next, 655);
      gnt_delay = 1;

      // Reset in the middle of READ after 5 captures
      @(negedge clk);
      rd_en = 1'b0;
      burst_caps = 0;
      c0 = tot_caps;
      p0 = dev_ptr;
      dev_total += 12;
      n = 0;
      while (n < 100 && burst_caps < 5) begin
         @(negedge clk);
         n++;
      end
      chk("mr_wait_timeout", n >= 100, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("mr_oe_n", ft601_oe_n, 1'b1);
      chk("mr_rd_n", ft601_rd_n, 1'b1);
      chk("mr_bus_req", bus_req, 1'b0);
      chk("mr_rd_valid", rd_valid, 1'b0);
      chk("mr_rd_count", rd_count, 0);
      chk("mr_taken", dev_ptr - p0, 5);
      repeat (3) @(negedge clk);
      exp_next = dev_ptr;
      #2 reset_n = 1'b1;
      rd_en = 1'b1;
      wait_done("reset_restart", 500);
      chk("mr_total_caps", tot_caps - c0, 12);
      chk("mr_delivered", exp_next, 667);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
